// File: rtl/shared_tlb_miss_arbiter.sv
// Arbitrates ITLB/DTLB misses onto the shared TLB and PTW, one miss in flight.
// Define SHARED_TLB_PERF_EN to build the shared-TLB hit/miss performance counters.
module shared_tlb_miss_arbiter #(
  parameter int unsigned VPN_W      = 27,
  parameter int unsigned PPN_W      = 44,
  parameter int unsigned ASID_W     = 16,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              itlb_req_i,
  input  logic [VPN_W-1:0]  itlb_vpn_i,
  output logic              itlb_gnt_o,
  input  logic              dtlb_req_i,
  input  logic [VPN_W-1:0]  dtlb_vpn_i,
  output logic              dtlb_gnt_o,
  output logic              resp_valid_o,
  output logic              resp_is_dtlb_o,
  output logic [PPN_W-1:0]  resp_ppn_o,
  output logic              resp_err_o,
  output logic              stlb_lookup_o,
  output logic [VPN_W-1:0]  stlb_vpn_o,
  output logic [ASID_W-1:0] stlb_asid_o,
  input  logic              stlb_hit_i,
  input  logic [PPN_W-1:0]  stlb_ppn_i,
  output logic              stlb_fill_o,
  output logic [PPN_W-1:0]  stlb_fill_ppn_o,
  output logic              ptw_req_o,
  output logic [VPN_W-1:0]  ptw_vpn_o,
  input  logic              ptw_ready_i,
  input  logic              ptw_done_i,
  input  logic [PPN_W-1:0]  ptw_ppn_i,
  input  logic              ptw_err_i,
  output logic              busy_o,
  output logic [31:0]       perf_hit_cnt_o,
  output logic [31:0]       perf_miss_cnt_o
);

  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [2:0] {
    StIdle, StLookup, StCheck, StWalkReq, StWalkWait, StResp, StDrain
  } state_e;

  state_e             state_q;
  logic [VPN_W-1:0]   vpn_q;
  logic [ASID_W-1:0]  asid_q;
  logic               owner_q;
  logic [PPN_W-1:0]   ppn_q;
  logic               err_q;
  logic [SW-1:0]      starve_q;
  logic               itlb_force;
  logic               idle_ok;

  assign idle_ok    = (state_q == StIdle) && !flush_i;
  assign itlb_force = (starve_q == SW'(STARVE_LIM));
  assign itlb_gnt_o = idle_ok && itlb_req_i && (!dtlb_req_i || itlb_force);
  assign dtlb_gnt_o = idle_ok && dtlb_req_i && !(itlb_req_i && itlb_force);

  assign busy_o          = (state_q != StIdle);
  assign stlb_lookup_o   = (state_q == StLookup);
  assign ptw_req_o       = (state_q == StWalkReq);
  assign resp_valid_o    = (state_q == StResp) && !flush_i;
  assign resp_is_dtlb_o  = owner_q;
  assign resp_ppn_o      = ppn_q;
  assign resp_err_o      = err_q;
  assign stlb_vpn_o      = vpn_q;
  assign stlb_asid_o     = asid_q;
  assign ptw_vpn_o       = vpn_q;
  // Fill lands in the ptw_done_i cycle so the shared TLB sees it before the response.
  assign stlb_fill_o     = (state_q == StWalkWait) && ptw_done_i && !ptw_err_i && !flush_i;
  assign stlb_fill_ppn_o = ptw_ppn_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (!itlb_req_i || itlb_gnt_o) begin
      starve_q <= '0;
    end else if (dtlb_gnt_o && !itlb_force) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      vpn_q   <= '0;
      asid_q  <= '0;
      owner_q <= 1'b0;
      ppn_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (itlb_gnt_o || dtlb_gnt_o) begin
            vpn_q   <= dtlb_gnt_o ? dtlb_vpn_i : itlb_vpn_i;
            owner_q <= dtlb_gnt_o;
            asid_q  <= asid_i;
            state_q <= StLookup;
          end
        end
        StLookup: state_q <= flush_i ? StIdle : StCheck;
        StCheck: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else if (stlb_hit_i) begin
            ppn_q   <= stlb_ppn_i;
            err_q   <= 1'b0;
            state_q <= StResp;
          end else begin
            state_q <= StWalkReq;
          end
        end
        StWalkReq: begin
          if (ptw_ready_i) begin
            state_q <= flush_i ? StDrain : StWalkWait;
          end else if (flush_i) begin
            state_q <= StIdle;
          end
        end
        StWalkWait: begin
          // A flush coinciding with completion has nothing left to drain.
          if (ptw_done_i) begin
            if (flush_i) begin
              state_q <= StIdle;
            end else begin
              ppn_q   <= ptw_ppn_i;
              err_q   <= ptw_err_i;
              state_q <= StResp;
            end
          end else if (flush_i) begin
            state_q <= StDrain;
          end
        end
        StResp:  state_q <= StIdle;
        StDrain: if (ptw_done_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SHARED_TLB_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StCheck) begin
      if (stlb_hit_i && hit_cnt_q != 32'hFFFF_FFFF) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else if (!stlb_hit_i && miss_cnt_q != 32'hFFFF_FFFF) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign perf_hit_cnt_o  = hit_cnt_q;
  assign perf_miss_cnt_o = miss_cnt_q;
`else
  assign perf_hit_cnt_o  = '0;
  assign perf_miss_cnt_o = '0;
`endif

endmodule
